// File: rtl/conv_decoder_if.sv
// Stride-instruction input and MAC tap-command output bundle for conv_decoder.
// The slave modport is the decoder side, the master modport is the driving/consuming side.
interface conv_decoder_if #(
    parameter int FA_W = 12,
    parameter int KA_W = 12,
    parameter int DW   = 32
);
    logic            inst_valid;
    logic            decoder_ready;
    logic [FA_W-1:0] inst_fbase;
    logic [KA_W-1:0] inst_kbase;
    logic [DW-1:0]   inst_chin;
    logic [DW-1:0]   inst_chout;
    logic [DW-1:0]   inst_width;
    logic [DW-1:0]   inst_height;
    logic [7:0]      inst_kh;
    logic [7:0]      inst_kw;
    logic            inst_has_bias;
    logic            inst_has_relu;
    logic [FA_W-1:0] inst_wbbase;
    logic [DW-1:0]   inst_wb_ch_offset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [FA_W-1:0] cmd_faddr;
    logic [KA_W-1:0] cmd_kaddr;
    logic            cmd_first;
    logic            cmd_last;
    logic            cmd_bias;
    logic            cmd_relu;
    logic [FA_W-1:0] cmd_wbaddr;

    modport master (
        output inst_valid, inst_fbase, inst_kbase, inst_chin, inst_chout, inst_width,
               inst_height, inst_kh, inst_kw, inst_has_bias, inst_has_relu, inst_wbbase,
               inst_wb_ch_offset, cmd_ready,
        input  decoder_ready, cmd_valid, cmd_faddr, cmd_kaddr, cmd_first, cmd_last,
               cmd_bias, cmd_relu, cmd_wbaddr
    );

    modport slave (
        input  inst_valid, inst_fbase, inst_kbase, inst_chin, inst_chout, inst_width,
               inst_height, inst_kh, inst_kw, inst_has_bias, inst_has_relu, inst_wbbase,
               inst_wb_ch_offset, cmd_ready,
        output decoder_ready, cmd_valid, cmd_faddr, cmd_kaddr, cmd_first, cmd_last,
               cmd_bias, cmd_relu, cmd_wbaddr
    );
endinterface

// File: rtl/conv_decoder.sv
// Expands one stride instruction into a serial stream of MAC tap commands (kx, ky, ci, co order).
// The per-chout bias fetch is compiled in only when DECODER_BIAS_EN is defined.
module conv_decoder #(
    parameter int FA_W = 12,
    parameter int KA_W = 12,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_decoder_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r, state_n;
    logic [DW-1:0]   chin_r, chin_n, chout_r, chout_n;
    logic [7:0]      kh_r, kh_n, kw_r, kw_n;
    logic [FA_W-1:0] fbase_r, fbase_n, width_r, width_n, wh_r, wh_n, wb_off_r, wb_off_n;
    logic            has_bias_r, has_bias_n;
    logic [DW-1:0]   co_r, co_n, ci_r, ci_n;
    logic [7:0]      ky_r, ky_n, kx_r, kx_n;
    logic [FA_W-1:0] ch_base_r, ch_base_n, row_base_r, row_base_n;
    logic            ready_r;
    logic            cmd_valid_r, cmd_valid_n, cmd_first_r, cmd_first_n;
    logic            cmd_last_r, cmd_last_n, cmd_bias_r, cmd_bias_n, cmd_relu_r, cmd_relu_n;
    logic [FA_W-1:0] cmd_faddr_r, cmd_faddr_n, cmd_wbaddr_r, cmd_wbaddr_n;
    logic [KA_W-1:0] cmd_kaddr_r, cmd_kaddr_n;
    logic [DW-1:0]   wh_full_s;
    logic            inst_bias_s, zero_size_s, last_weight_s, weight_step_s;

    assign wh_full_s = bus.inst_width * bus.inst_height;

`ifdef DECODER_BIAS_EN
    assign inst_bias_s = bus.inst_has_bias;
`else
    assign inst_bias_s = 1'b0;
`endif

    assign zero_size_s = (bus.inst_chin == DW'(0)) || (bus.inst_chout == DW'(0)) ||
                         (bus.inst_kh == 8'd0) || (bus.inst_kw == 8'd0);

    // Only reachable with bias enabled: without bias the last weight tap already carries cmd_last.
    assign last_weight_s = !cmd_bias_r && (kx_r == kw_r - 8'd1) && (ky_r == kh_r - 8'd1) &&
                           (ci_r == chin_r - DW'(1));

    // Next-state, instruction latch and next-command computation.
    always_comb begin
        state_n       = state_r;
        chin_n        = chin_r;
        chout_n       = chout_r;
        kh_n          = kh_r;
        kw_n          = kw_r;
        fbase_n       = fbase_r;
        width_n       = width_r;
        wh_n          = wh_r;
        wb_off_n      = wb_off_r;
        has_bias_n    = has_bias_r;
        co_n          = co_r;
        ci_n          = ci_r;
        ky_n          = ky_r;
        kx_n          = kx_r;
        ch_base_n     = ch_base_r;
        row_base_n    = row_base_r;
        cmd_valid_n   = cmd_valid_r;
        cmd_first_n   = cmd_first_r;
        cmd_last_n    = cmd_last_r;
        cmd_bias_n    = cmd_bias_r;
        cmd_relu_n    = cmd_relu_r;
        cmd_faddr_n   = cmd_faddr_r;
        cmd_kaddr_n   = cmd_kaddr_r;
        cmd_wbaddr_n  = cmd_wbaddr_r;
        weight_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.inst_valid) begin
                    state_n       = RUN;
                    chin_n        = bus.inst_chin;
                    chout_n       = bus.inst_chout;
                    kh_n          = bus.inst_kh;
                    kw_n          = bus.inst_kw;
                    fbase_n       = bus.inst_fbase;
                    width_n       = FA_W'(bus.inst_width);
                    wh_n          = FA_W'(wh_full_s);
                    wb_off_n      = FA_W'(bus.inst_wb_ch_offset);
                    has_bias_n    = inst_bias_s;
                    co_n          = DW'(0);
                    ci_n          = DW'(0);
                    ky_n          = 8'd0;
                    kx_n          = 8'd0;
                    ch_base_n     = bus.inst_fbase;
                    row_base_n    = bus.inst_fbase;
                    cmd_faddr_n   = bus.inst_fbase;
                    cmd_kaddr_n   = bus.inst_kbase;
                    cmd_wbaddr_n  = bus.inst_wbbase;
                    cmd_relu_n    = bus.inst_has_relu;
                    cmd_valid_n   = !zero_size_s;
                    cmd_first_n   = 1'b1;
                    cmd_bias_n    = 1'b0;
                    weight_step_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (!cmd_valid_r) begin
                    state_n = IDLE;
                end else if (bus.cmd_ready) begin
                    cmd_kaddr_n = cmd_kaddr_r + KA_W'(1);
                    cmd_first_n = 1'b0;
                    if (cmd_last_r) begin
                        if (co_r == chout_r - DW'(1)) begin
                            state_n     = IDLE;
                            cmd_valid_n = 1'b0;
                            cmd_last_n  = 1'b0;
                            cmd_bias_n  = 1'b0;
                        end else begin
                            co_n          = co_r + DW'(1);
                            ci_n          = DW'(0);
                            ky_n          = 8'd0;
                            kx_n          = 8'd0;
                            ch_base_n     = fbase_r;
                            row_base_n    = fbase_r;
                            cmd_faddr_n   = fbase_r;
                            cmd_wbaddr_n  = cmd_wbaddr_r + wb_off_r;
                            cmd_first_n   = 1'b1;
                            cmd_bias_n    = 1'b0;
                            weight_step_s = 1'b1;
                        end
                    end else if (last_weight_s) begin
                        cmd_bias_n = 1'b1;
                        cmd_last_n = 1'b1;
                    end else if (kx_r != kw_r - 8'd1) begin
                        kx_n          = kx_r + 8'd1;
                        cmd_faddr_n   = cmd_faddr_r + FA_W'(1);
                        weight_step_s = 1'b1;
                    end else if (ky_r != kh_r - 8'd1) begin
                        kx_n          = 8'd0;
                        ky_n          = ky_r + 8'd1;
                        row_base_n    = row_base_r + width_r;
                        cmd_faddr_n   = row_base_r + width_r;
                        weight_step_s = 1'b1;
                    end else begin
                        kx_n          = 8'd0;
                        ky_n          = 8'd0;
                        ci_n          = ci_r + DW'(1);
                        ch_base_n     = ch_base_r + wh_r;
                        row_base_n    = ch_base_r + wh_r;
                        cmd_faddr_n   = ch_base_r + wh_r;
                        weight_step_s = 1'b1;
                    end
                end else begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n     = IDLE;
                cmd_valid_n = 1'b0;
            end
        endcase
        // A new weight tap is last when it closes the chout and no bias word follows it.
        cmd_last_n = weight_step_s ?
                     (!has_bias_n && (kx_n == kw_n - 8'd1) && (ky_n == kh_n - 8'd1) &&
                      (ci_n == chin_n - DW'(1))) : cmd_last_n;
    end

    // State, latched instruction fields, tap counters and registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            chin_r       <= DW'(0);
            chout_r      <= DW'(0);
            kh_r         <= 8'd0;
            kw_r         <= 8'd0;
            fbase_r      <= FA_W'(0);
            width_r      <= FA_W'(0);
            wh_r         <= FA_W'(0);
            wb_off_r     <= FA_W'(0);
            has_bias_r   <= 1'b0;
            co_r         <= DW'(0);
            ci_r         <= DW'(0);
            ky_r         <= 8'd0;
            kx_r         <= 8'd0;
            ch_base_r    <= FA_W'(0);
            row_base_r   <= FA_W'(0);
            ready_r      <= 1'b1;
            cmd_valid_r  <= 1'b0;
            cmd_first_r  <= 1'b0;
            cmd_last_r   <= 1'b0;
            cmd_bias_r   <= 1'b0;
            cmd_relu_r   <= 1'b0;
            cmd_faddr_r  <= FA_W'(0);
            cmd_kaddr_r  <= KA_W'(0);
            cmd_wbaddr_r <= FA_W'(0);
        end else begin
            state_r      <= state_n;
            chin_r       <= chin_n;
            chout_r      <= chout_n;
            kh_r         <= kh_n;
            kw_r         <= kw_n;
            fbase_r      <= fbase_n;
            width_r      <= width_n;
            wh_r         <= wh_n;
            wb_off_r     <= wb_off_n;
            has_bias_r   <= has_bias_n;
            co_r         <= co_n;
            ci_r         <= ci_n;
            ky_r         <= ky_n;
            kx_r         <= kx_n;
            ch_base_r    <= ch_base_n;
            row_base_r   <= row_base_n;
            ready_r      <= (state_n == IDLE);
            cmd_valid_r  <= cmd_valid_n;
            cmd_first_r  <= cmd_first_n;
            cmd_last_r   <= cmd_last_n;
            cmd_bias_r   <= cmd_bias_n;
            cmd_relu_r   <= cmd_relu_n;
            cmd_faddr_r  <= cmd_faddr_n;
            cmd_kaddr_r  <= cmd_kaddr_n;
            cmd_wbaddr_r <= cmd_wbaddr_n;
        end
    end

    assign bus.decoder_ready = ready_r;
    assign bus.cmd_valid     = cmd_valid_r;
    assign bus.cmd_faddr     = cmd_faddr_r;
    assign bus.cmd_kaddr     = cmd_kaddr_r;
    assign bus.cmd_first     = cmd_first_r;
    assign bus.cmd_last      = cmd_last_r;
    assign bus.cmd_bias      = cmd_bias_r;
    assign bus.cmd_relu      = cmd_relu_r;
    assign bus.cmd_wbaddr    = cmd_wbaddr_r;

endmodule

// File: tb/tb_conv_decoder.sv
// Self-checking bench for conv_decoder: directed scenarios and randomized instructions
// compared against a loop-nest reference model of the tap command stream.
module tb_conv_decoder;
    localparam int FA_W = 12;
    localparam int KA_W = 12;
    localparam int DW   = 32;
`ifdef DECODER_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] faddr;
        logic [11:0] kaddr;
        logic        first;
        logic        last;
        logic        bias;
        logic        relu;
        logic [11:0] wbaddr;
    } cmd_t;

    typedef struct {
        int unsigned fbase, kbase, chin, chout, width, height, kh, kw;
        int unsigned has_bias, has_relu, wbbase, wb_off;
    } inst_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    conv_decoder_if #(.FA_W(FA_W), .KA_W(KA_W), .DW(DW)) bus ();
    conv_decoder #(.FA_W(FA_W), .KA_W(KA_W), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic inst_t mk(input int unsigned fbase, kbase, chin, chout, width, height,
                                 kh, kw, has_bias, has_relu, wbbase, wb_off);
        inst_t i;
        i.fbase = fbase; i.kbase = kbase; i.chin = chin; i.chout = chout;
        i.width = width; i.height = height; i.kh = kh; i.kw = kw;
        i.has_bias = has_bias; i.has_relu = has_relu; i.wbbase = wbbase; i.wb_off = wb_off;
        return i;
    endfunction

    // Reference: walk the loop nest and write every address with plain arithmetic.
    function automatic void build_expected(input inst_t i, output cmd_t q[$]);
        longint unsigned k = 0;
        bit bias = BIAS_EN && (i.has_bias != 0);
        cmd_t c;
        q.delete();
        if (i.chin == 0 || i.chout == 0 || i.kh == 0 || i.kw == 0) return;
        for (longint unsigned co = 0; co < i.chout; co++) begin
            for (longint unsigned ci = 0; ci < i.chin; ci++)
                for (longint unsigned ky = 0; ky < i.kh; ky++)
                    for (longint unsigned kx = 0; kx < i.kw; kx++) begin
                        c.faddr  = 12'((64'(i.fbase) + ci * i.width * i.height + ky * i.width + kx) % 64'd4096);
                        c.kaddr  = 12'((64'(i.kbase) + k) % 64'd4096);
                        c.first  = (ci == 0 && ky == 0 && kx == 0);
                        c.last   = !bias && ci == i.chin - 1 && ky == i.kh - 1 && kx == i.kw - 1;
                        c.bias   = 1'b0;
                        c.relu   = i.has_relu[0];
                        c.wbaddr = 12'((64'(i.wbbase) + co * i.wb_off) % 64'd4096);
                        q.push_back(c);
                        k++;
                    end
            if (bias) begin
                c.faddr = 12'd0; c.kaddr = 12'((64'(i.kbase) + k) % 64'd4096);
                c.first = 1'b0; c.last = 1'b1; c.bias = 1'b1;
                q.push_back(c);
                k++;
            end
        end
    endfunction

    function automatic cmd_t mask(input cmd_t c);
        cmd_t m = c;
        if (c.bias) m.faddr = 12'd0;
        return m;
    endfunction

    task automatic drive_inst(input inst_t i);
        bus.inst_fbase = FA_W'(i.fbase);   bus.inst_kbase  = KA_W'(i.kbase);
        bus.inst_chin  = i.chin;           bus.inst_chout  = i.chout;
        bus.inst_width = i.width;          bus.inst_height = i.height;
        bus.inst_kh    = 8'(i.kh);         bus.inst_kw     = 8'(i.kw);
        bus.inst_has_bias = i.has_bias[0]; bus.inst_has_relu = i.has_relu[0];
        bus.inst_wbbase   = FA_W'(i.wbbase); bus.inst_wb_ch_offset = i.wb_off;
        bus.inst_valid = 1'b1;
        @(posedge clk); #1;
        bus.inst_valid = 1'b0;
    endtask

    // mode 0: always ready; 1: 1010.. with a 5-cycle low stretch; 2: random.
    task automatic collect(input int mode, input int budget, output cmd_t got[$], output int busy,
                           output int unstable, output int stalls, output bit timeout);
        cmd_t cur, held;
        bit held_v = 1'b0;
        bit rdy;
        got.delete(); busy = 0; unstable = 0; stalls = 0; timeout = 1'b0;
        while (bus.decoder_ready !== 1'b1) begin
            if (busy >= budget) begin timeout = 1'b1; break; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (busy >= 8 && busy < 13) ? 1'b0 : (busy % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cur = {bus.cmd_faddr, bus.cmd_kaddr, bus.cmd_first, bus.cmd_last,
                   bus.cmd_bias, bus.cmd_relu, bus.cmd_wbaddr};
            if (held_v && (bus.cmd_valid !== 1'b1 || cur !== held)) unstable++;
            bus.cmd_ready = rdy;
            if (bus.cmd_valid === 1'b1 && rdy) got.push_back(cur);
            if (bus.cmd_valid === 1'b1 && !rdy) begin held_v = 1'b1; held = cur; stalls++; end
            else held_v = 1'b0;
            @(posedge clk); #1;
            busy++;
        end
        bus.cmd_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_valid, bus.cmd_first, bus.cmd_last, bus.cmd_bias, bus.cmd_relu,
             bus.cmd_faddr, bus.cmd_kaddr, bus.cmd_wbaddr} !== 41'd0) begin
            errors++; $display("FAIL reset_cmd got %h exp 0", {bus.cmd_valid, bus.cmd_faddr, bus.cmd_kaddr, bus.cmd_wbaddr});
        end
        checks++;
        if (bus.decoder_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.decoder_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_tap();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        inst_t i = mk(7, 3, 1, 1, 4, 4, 1, 1, 0, 1, 50, 9);
        build_expected(i, exp);
        drive_inst(i);
        collect(0, 50, got, busy, uns, st, to);
        checks++;
        if (got.size() !== 1 || to) begin errors++; $display("FAIL t1_count got %0d exp 1 timeout %b", got.size(), to); end
        else begin
            checks++;
            if (got[0] !== {12'd7, 12'd3, 1'b1, 1'b1, 1'b0, 1'b1, 12'd50}) begin
                errors++; $display("FAIL t1_cmd got %h exp %h", got[0], exp[0]);
            end
        end
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL t1_ready_low got %0d exp 1", busy); end
    endtask

    task automatic test_3x3();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        int exp_f[18] = '{10, 11, 12, 15, 16, 17, 20, 21, 22, 35, 36, 37, 40, 41, 42, 45, 46, 47};
        inst_t i = mk(10, 0, 2, 1, 5, 5, 3, 3, 0, 0, 0, 0);
        build_expected(i, exp);
        drive_inst(i);
        collect(0, 100, got, busy, uns, st, to);
        checks++;
        if (got.size() !== 18 || to) begin errors++; $display("FAIL t2_count got %0d exp 18", got.size()); end
        for (int k = 0; k < got.size() && k < 18; k++) begin
            checks++;
            if (got[k].faddr !== 12'(exp_f[k]) || got[k].kaddr !== 12'(k) || got[k].last !== (k == 17) ||
                got[k].first !== (k == 0) || mask(got[k]) !== mask(exp[k])) begin
                errors++; $display("FAIL t2_cmd[%0d] got %h exp %h", k, got[k], exp[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        inst_t i = mk(10, 0, 2, 1, 5, 5, 3, 3, 0, 0, 0, 0);
        build_expected(i, exp);
        drive_inst(i);
        collect(1, 200, got, busy, uns, st, to);
        checks++;
        if (got.size() !== exp.size() || to) begin errors++; $display("FAIL t3_count got %0d exp %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (mask(got[k]) !== mask(exp[k])) begin errors++; $display("FAIL t3_cmd[%0d] got %h exp %h", k, got[k], exp[k]); end
        end
        checks++;
        if (uns !== 0 || st < 5) begin errors++; $display("FAIL t3_stable unstable %0d stalls %0d exp 0 and >=5", uns, st); end
    endtask

    task automatic test_bias();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        int per = BIAS_EN ? 5 : 4;
        int nb = 0;
        inst_t i = mk(0, 0, 1, 2, 4, 4, 2, 2, 1, 0, 100, 16);
        build_expected(i, exp);
        drive_inst(i);
        collect(0, 100, got, busy, uns, st, to);
        checks++;
        if (got.size() !== 2 * per || to) begin errors++; $display("FAIL t4_count got %0d exp %0d", got.size(), 2 * per); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (mask(got[k]) !== mask(exp[k]) || got[k].wbaddr !== ((k < per) ? 12'd100 : 12'd116) ||
                got[k].kaddr !== 12'(k)) begin
                errors++; $display("FAIL t4_cmd[%0d] got %h exp %h", k, got[k], exp[k]);
            end
            if (got[k].bias === 1'b1) nb++;
        end
        checks++;
        if (nb !== (BIAS_EN ? 2 : 0)) begin errors++; $display("FAIL t4_bias_cnt got %0d exp %0d", nb, BIAS_EN ? 2 : 0); end
    endtask

    task automatic test_zero_size();
        cmd_t got[$]; int busy, uns, st; bit to;
        drive_inst(mk(5, 5, 2, 0, 3, 3, 3, 3, 1, 1, 0, 0));
        collect(0, 20, got, busy, uns, st, to);
        checks++;
        if (got.size() !== 0 || busy !== 1 || to) begin
            errors++; $display("FAIL t5_zero got cmds %0d ready_low %0d exp 0 and 1", got.size(), busy);
        end
    endtask

    task automatic test_ignore_in_run();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        inst_t i = mk(200, 40, 2, 2, 3, 2, 2, 2, 0, 1, 7, 5);
        build_expected(i, exp);
        drive_inst(i);
        bus.inst_valid = 1'b1; bus.inst_fbase = 12'd999; bus.inst_chin = 32'd7; bus.inst_kw = 8'd5;
        collect(2, 300, got, busy, uns, st, to);
        bus.inst_valid = 1'b0;
        checks++;
        if (got.size() !== exp.size() || to) begin errors++; $display("FAIL run_ignore_count got %0d exp %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (mask(got[k]) !== mask(exp[k])) begin errors++; $display("FAIL run_ignore_cmd[%0d] got %h exp %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_random();
        cmd_t got[$], exp[$]; int busy, uns, st; bit to;
        inst_t i;
        for (int n = 0; n < 30; n++) begin
            i = mk($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 3), $urandom_range(1, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 9), $urandom_range(1, 9),
                   $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 4095), $urandom);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       i.chin = 0;
                    1:       i.chout = 0;
                    2:       i.kh = 0;
                    default: i.kw = 0;
                endcase
            end
            build_expected(i, exp);
            drive_inst(i);
            collect(2, 2000, got, busy, uns, st, to);
            checks++;
            if (got.size() !== exp.size() || to || uns !== 0) begin
                errors++; $display("FAIL rnd%0d_count got %0d exp %0d unstable %0d", n, got.size(), exp.size(), uns);
            end
            for (int k = 0; k < got.size() && k < exp.size(); k++) begin
                checks++;
                if (mask(got[k]) !== mask(exp[k])) begin errors++; $display("FAIL rnd%0d_cmd[%0d] got %h exp %h", n, k, got[k], exp[k]); end
            end
            if (exp.size() == 0) begin
                checks++;
                if (busy !== 1) begin errors++; $display("FAIL rnd%0d_zero_ready_low got %0d exp 1", n, busy); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int acc = 0;
        int cyc = 0;
        drive_inst(mk(10, 0, 2, 1, 5, 5, 3, 3, 0, 0, 0, 0));
        bus.cmd_ready = 1'b1;
        while (acc < 6 && cyc < 40) begin
            if (bus.cmd_valid === 1'b1) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (acc !== 6) begin errors++; $display("FAIL t6_accepts got %0d exp 6", acc); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.decoder_ready !== 1'b1) begin
            errors++; $display("FAIL t6_async got valid %b ready %b exp 0 1", bus.cmd_valid, bus.decoder_ready);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_single_tap();
    endtask

    initial begin
        bus.inst_valid = 1'b0; bus.cmd_ready = 1'b1;
        bus.inst_fbase = 12'd0; bus.inst_kbase = 12'd0; bus.inst_chin = 32'd0; bus.inst_chout = 32'd0;
        bus.inst_width = 32'd0; bus.inst_height = 32'd0; bus.inst_kh = 8'd0; bus.inst_kw = 8'd0;
        bus.inst_has_bias = 1'b0; bus.inst_has_relu = 1'b0; bus.inst_wbbase = 12'd0; bus.inst_wb_ch_offset = 32'd0;
        test_reset();
        test_single_tap();
        test_3x3();
        test_backpressure();
        test_bias();
        test_zero_size();
        test_ignore_in_run();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
